// File: rtl/div_pkg.sv
// Shared types and constants for the DIV/HI/LO sequencer.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_e;

  localparam int DIV_LATENCY_DEFAULT = 34;

  // Wide enough for any practical WIDTH; users slice the low bits.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_hilo_ctrl_twos_negate.sv
// Conditional two's-complement negate, wraps mod 2^WIDTH.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign out = en ? (~in + ONE) : in;

endmodule

// File: rtl/div_hilo_ctrl.sv
// DIV instruction sequencer: signs, divider handshake,
// sign fix-up and HI/LO write-back around div_32_bit.
module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_resetn,
  output logic [WIDTH-1:0] div_Q,
  output logic [WIDTH-1:0] div_M,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ZQ =
    DIV_ZERO_QUOTIENT[WIDTH-1:0];

  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, rneg_q;
  logic a_neg, b_neg;
  logic take_op, take_zero, wr_fix;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];

  twos_negate #(.WIDTH(WIDTH)) u_mag_a (
    .en (a_neg),
    .in (dividend),
    .out(mag_a)
  );

  twos_negate #(.WIDTH(WIDTH)) u_mag_b (
    .en (b_neg),
    .in (divisor),
    .out(mag_b)
  );

  twos_negate #(.WIDTH(WIDTH)) u_fix_q (
    .en (qneg_q),
    .in (div_quotient),
    .out(q_fix)
  );

  twos_negate #(.WIDTH(WIDTH)) u_fix_r (
    .en (rneg_q),
    .in (div_remainder),
    .out(r_fix)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_op   = 1'b0;
    take_zero = 1'b0;
    wr_fix    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            take_zero = 1'b1;
            state_d   = S_DONE;
          end else begin
            take_op = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        wr_fix  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Divider stays out of reset through FIX so its result holds.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_resetn  <= 1'b0;
      div_Q       <= '0;
      div_M       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      div_resetn <= (state_d == S_RUN) ||
                    (state_d == S_FIX);
      if (take_op) begin
        div_Q       <= mag_a;
        div_M       <= mag_b;
        qneg_q      <= a_neg ^ b_neg;
        rneg_q      <= a_neg;
        div_by_zero <= 1'b0;
      end
      if (take_zero) begin
        lo_out      <= ZQ;
        hi_out      <= dividend;
        div_by_zero <= 1'b1;
      end
      if (wr_fix) begin
        lo_out <= q_fix;
        hi_out <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl with a divider
// stand-in and a cycle-level behavioural reference.
module tb_div_hilo_ctrl;

  localparam int W = 32;
  localparam int L = 34;
  localparam logic [31:0] GARB = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_resetn;
  logic [31:0] div_Q;
  logic [31:0] div_M;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.WIDTH(W), .DIV_LATENCY(L)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .div_resetn   (div_resetn),
    .div_Q        (div_Q),
    .div_M        (div_M),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  // Divider stand-in: result valid only after L enabled edges.
  int dcnt = 0;
  always @(posedge clk) begin
    if (!div_resetn) dcnt <= 0;
    else if (dcnt < L) dcnt <= dcnt + 1;
  end
  assign div_quotient =
    (dcnt >= L && div_M != 0) ? div_Q / div_M : GARB;
  assign div_remainder =
    (dcnt >= L && div_M != 0) ? div_Q % div_M : ~GARB;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic sg,
                                      input logic [31:0] x);
    return (sg && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic void ref_div(input logic sg,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Reference: m_left counts edges until the unit is idle again.
  int          m_left = 0;
  bit          m_on = 0;
  bit          m_zero = 0;
  logic        m_dbz;
  logic [31:0] m_hi, m_lo, m_q, m_m, p_hi, p_lo;

  always @(posedge clk) begin
    if (!resetn) begin
      m_on   = 1;
      m_left = 0;
      m_zero = 0;
      m_dbz  = 0;
      m_hi   = 0;
      m_lo   = 0;
      m_q    = 0;
      m_m    = 0;
    end else if (m_left == 0) begin
      if (start) begin
        ref_div(is_signed, dividend, divisor, p_lo, p_hi);
        if (divisor == 0) begin
          m_lo   = p_lo;
          m_hi   = p_hi;
          m_dbz  = 1;
          m_zero = 1;
          m_left = 1;
        end else begin
          m_q    = mag(is_signed, dividend);
          m_m    = mag(is_signed, divisor);
          m_dbz  = 0;
          m_zero = 0;
          m_left = L + 3;
        end
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_lo = p_lo;
        m_hi = p_hi;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_left == 1));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("div_resetn", 32'(div_resetn),
          32'(!m_zero && m_left >= 2 && m_left <= L + 2));
      chk("div_Q", div_Q, m_q);
      chk("div_M", div_M, m_m);
    end
  end

  task automatic do_op(input logic sg,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start     = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_done(input string nm, output int lat);
    int n = 0;
    lat = -1;
    while (n < 100) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (lat < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_lit(input string nm,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] lo,
                         input logic [31:0] hi,
                         input logic dz,
                         input int lat_exp);
    int lat;
    do_op(sg, a, b);
    wait_done(nm, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({nm, "_lo"}, lo_out, lo);
    chk({nm, "_hi"}, hi_out, hi);
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(dz));
  endtask

  initial begin
    int lat;
    logic sg;
    logic [31:0] a, b, q, r;
    resetn    = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_divrst", 32'(div_resetn), 32'd0);
    resetn = 1'b1;

    run_lit("u38_6", 0, 32'd38, 32'd6,
            32'd6, 32'd2, 0, 36);
    run_lit("sm38_6", 1, 32'hFFFF_FFDA, 32'd6,
            32'hFFFF_FFFA, 32'hFFFF_FFFE, 0, 36);
    run_lit("s38_m6", 1, 32'd38, 32'hFFFF_FFFA,
            32'hFFFF_FFFA, 32'd2, 0, 36);
    run_lit("u100_0", 0, 32'd100, 32'd0,
            32'hFFFF_FFFF, 32'd100, 1, 0);
    run_lit("s_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 0, 36);
    run_lit("u7f_1", 0, 32'h7FFF_FFFF, 32'd1,
            32'h7FFF_FFFF, 32'd0, 0, 36);
    run_lit("u_min", 0, 32'h8000_0000, 32'd3,
            32'h2AAA_AAAA, 32'd2, 0, 36);

    do_op(0, 32'd1, 32'd50);
    repeat (8) @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 32'd999;
    divisor   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", lat);
    chk("ign_lo", lo_out, 32'd0);
    chk("ign_hi", hi_out, 32'd1);
    repeat (5) @(negedge clk);

    do_op(0, 32'd1000, 32'd7);
    repeat (18) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_lo", lo_out, 32'd0);
    chk("mid_divrst", 32'(div_resetn), 32'd0);
    chk("mid_Q", div_Q, 32'd0);
    repeat (40) @(negedge clk);
    run_lit("u100_25", 0, 32'd100, 32'd25,
            32'd4, 32'd0, 0, 36);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      ref_div(sg, a, b, q, r);
      run_lit("rnd", sg, a, b, q, r, 1'(b == 0),
              (b == 0) ? 0 : 36);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Sequencer that sits directly upstream and downstream of the 32-bit iterative unsigned divider (`div_32_bit`) and turns it into a usable DIV instruction unit. It accepts a divide request from the datapath control unit and handles signed operands by feeding magnitudes to the divider. It pulses the divider's reset, waits the divider's fixed iteration latency, then applies sign correction and writes the quotient into LO and the remainder into HI. Divide-by-zero is detected and resolved without starting the divider.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; must match the divider.
- `DIV_LATENCY`, 34, cycles the divider needs after its reset is released before quotient/remainder are valid.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset. Synchronous, active-low.
- `start`  in  1  request a divide; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `dividend`  in  WIDTH  captured with `start`.
- `divisor`  in  WIDTH  captured with `start`.
- `busy`  out  1  high from the edge that accepts `start` until return to IDLE.
- `done`  out  1  single-cycle pulse; HI/LO are valid.
- `div_by_zero`  out  1  sticky flag for the last operation; cleared on the next accepted `start`.
- `hi_out`  out  WIDTH  HI register (remainder).
- `lo_out`  out  WIDTH  LO register (quotient).
- `div_resetn`  out  1  to divider `resetn`.
- `div_Q`  out  WIDTH  to divider `Q`; registered dividend magnitude.
- `div_M`  out  WIDTH  to divider `M`; registered divisor magnitude.
- `div_quotient`  in  WIDTH  from divider.
- `div_remainder`  in  WIDTH  from divider.

## Operation

- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE:
  - `div_resetn`=0.
  - On `start` with `divisor`≠0: latch signs, register magnitudes into `div_Q`/`div_M`, go to LOAD.
  - On `start` with `divisor`==0: write LO=all-ones and HI=`dividend`, set `div_by_zero`, go to DONE.
- LOAD: `div_resetn`=0 for exactly one cycle with operands stable. Go to RUN and clear the counter.
- RUN: `div_resetn`=1. Count DIV_LATENCY cycles, then go to FIX.
- FIX:
  - Quotient is negated if `is_signed` and the operand signs differ.
  - Remainder is negated if `is_signed` and the dividend is negative.
  - Write LO/HI at the exit edge and go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Magnitudes:
  - Unsigned mode passes operands through unchanged.
  - Signed mode uses two's-complement negation, mod 2^WIDTH. The magnitude of 0x80000000 is 0x80000000, which the divider treats as unsigned.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No flag is raised.
- `start` while `busy` is ignored (not queued). Operand changes after acceptance have no effect.

## Timing

- Reset (`resetn`=0 at an edge), from any state including mid-RUN:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `hi_out`=`lo_out`=0, `div_Q`=`div_M`=0, `div_resetn`=0.
  - Any in-flight result is discarded.
- Normal latency, with `start` accepted at edge E0:
  - LOAD is E0→E1.
  - RUN spans E1→E(1+DIV_LATENCY).
  - HI/LO update at edge E(DIV_LATENCY+2).
  - `done` is high during the cycle following that edge. The default latency is 36 cycles.
- Divide-by-zero latency: HI/LO update at E0, and `done` is high in the cycle after E0.
- `busy` falls at the edge that leaves DONE. A new `start` is accepted at that same edge only if the state is already IDLE, so it is accepted no earlier than the next edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- `div_pkg`:
  - State enum.
  - `DIV_LATENCY_DEFAULT`=34.
  - `DIV_ZERO_QUOTIENT`=all-ones constant.
- One sub-module, `twos_negate`: combinational conditional negate (`en`, `in`, `out`). It is instantiated for dividend magnitude, divisor magnitude, quotient fix and remainder fix.
- The divider itself is instantiated beside this block in the datapath, not inside it.

## Test plan

- Unsigned 38 / 6 → after 36 cycles `done`, LO=6, HI=2, `div_by_zero`=0.
- Signed −38 (0xFFFFFFDA) / 6 → LO=0xFFFFFFFA (−6), HI=0xFFFFFFFE (−2). Also 38 / −6 → LO=−6, HI=2.
- Unsigned 100 / 0 → `done` one cycle after `start`, `div_by_zero`=1, LO=0xFFFFFFFF, HI=100, `div_resetn` never rises.
- Signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Unsigned 0x7FFFFFFF / 1 → LO=0x7FFFFFFF, HI=0.
- Issue 1 / 50 and pulse `start` with other operands at cycle 10 → second `start` ignored, LO=0, HI=1, exactly one `done`.
- Assert `resetn`=0 for one edge mid-RUN (cycle 20) → all outputs at reset values, no `done`. A following 100 / 25 completes normally with LO=4, HI=0.
